// File: rtl/cpu_retire_tracer.sv
// Retirement tracer: counts cycles/retires, keeps the last DEPTH (pc, instr) pairs, drains on halt.
// Optional watchdog enabled by defining TRACE_WATCHDOG_EN.
module cpu_retire_tracer #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             retire_valid,
    input  logic [XLEN-1:0]  retire_pc,
    input  logic [31:0]      retire_instr,
    input  logic             halt_in,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [XLEN-1:0]  rd_pc,
    output logic [31:0]      rd_instr,
    output logic             rd_last,
    output logic             capturing,
    output logic             done,
    output logic             overflow,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] OccFull = (PtrW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StCapture, StDrain, StDone} state_e;

    state_e              state;
    logic [PtrW-1:0]     wr_ptr;
    logic [PtrW-1:0]     rd_ptr;
    logic [PtrW:0]       occ;
    logic [XLEN-1:0]     mem_pc    [DEPTH];
    logic [31:0]         mem_instr [DEPTH];

`ifdef TRACE_WATCHDOG_EN
    logic wdog_hit;
    assign wdog_hit = (cycle_count == CNT_W'(WDOG_CYCLES - 1));
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_CYCLES;
    assign timeout     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            overflow    <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
`ifdef TRACE_WATCHDOG_EN
            timeout     <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle, StDone: begin
                    if (arm) begin
                        wr_ptr      <= '0;
                        rd_ptr      <= '0;
                        occ         <= '0;
                        overflow    <= 1'b0;
                        cycle_count <= '0;
                        instr_count <= '0;
`ifdef TRACE_WATCHDOG_EN
                        timeout     <= 1'b0;
`endif
                        state       <= StCapture;
                    end
                end
                StCapture: begin
                    if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
                    if (retire_valid) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (instr_count != '1) instr_count <= instr_count + 1'b1;
                        // Full buffer: the oldest entry is overwritten, so the head advances.
                        if (occ == OccFull) begin
                            rd_ptr   <= rd_ptr + 1'b1;
                            overflow <= 1'b1;
                        end else begin
                            occ <= occ + 1'b1;
                        end
                    end
                    if (halt_in) begin
                        state <= StDrain;
                    end
`ifdef TRACE_WATCHDOG_EN
                    else if (wdog_hit) begin
                        timeout <= 1'b1;
                        state   <= StDrain;
                    end
`endif
                end
                StDrain: begin
                    if (occ == '0) begin
                        state <= StDone;
                    end else if (rd_ready) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        occ    <= occ - 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == StCapture && retire_valid) begin
            mem_pc[wr_ptr]    <= retire_pc;
            mem_instr[wr_ptr] <= retire_instr;
        end
    end

    always_comb begin
        rd_valid = 1'b0;
        rd_last  = 1'b0;
        rd_pc    = '0;
        rd_instr = '0;
        if (state == StDrain) begin
            rd_valid = (occ != '0);
            rd_last  = (occ == (PtrW + 1)'(1));
            rd_pc    = mem_pc[rd_ptr];
            rd_instr = mem_instr[rd_ptr];
        end
    end

    assign capturing = (state == StCapture);
    assign done      = (state == StDone);

endmodule

// File: tb/tb_cpu_retire_tracer.sv
// Directed bench for cpu_retire_tracer; honours TRACE_WATCHDOG_EN when defined.
module tb_cpu_retire_tracer;

    logic        clk = 1'b0;
    logic        rst, arm, retire_valid, halt_in, rd_ready;
    logic [31:0] retire_pc, retire_instr;
    logic        rd_valid, rd_last, capturing, done, overflow, timeout;
    logic [31:0] rd_pc, rd_instr, cycle_count, instr_count;

    int n_asserts = 0;
    int n_fail    = 0;

    cpu_retire_tracer #(
        .XLEN(32), .DEPTH(16), .CNT_W(32), .WDOG_CYCLES(64)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
        .halt_in(halt_in),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_instr(rd_instr),
        .rd_last(rd_last), .capturing(capturing), .done(done), .overflow(overflow),
        .timeout(timeout), .cycle_count(cycle_count), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check(tag, done, 1);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; retire_valid = 1'b0; halt_in = 1'b0; rd_ready = 1'b0;
        retire_pc = '0; retire_instr = '0;
        tick(); tick();
        rst = 1'b0;

        check("rst_capturing", capturing, 0);
        check("rst_done", done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_cycles", cycle_count, 0);
        check("rst_instrs", instr_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_timeout", timeout, 0);

        // Reset in the middle of a capture run
        do_arm();
        check("t1_capturing", capturing, 1);
        for (int i = 0; i < 5; i++) begin
            retire_valid = 1'b1; retire_pc = 32'(i * 4); retire_instr = 32'h13 + 32'(i * 4);
            tick();
        end
        retire_valid = 1'b0;
        check("t1_instrs", instr_count, 5);
        check("t1_cycles", cycle_count, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t1_rst_capturing", capturing, 0);
        check("t1_rst_instrs", instr_count, 0);
        check("t1_rst_cycles", cycle_count, 0);
        check("t1_rst_rd_valid", rd_valid, 0);
        check("t1_rst_done", done, 0);

        // Three retires then halt, drain in order
        do_arm();
        for (int i = 0; i < 3; i++) begin
            retire_valid = 1'b1; retire_pc = 32'(i * 4); retire_instr = 32'h13 + 32'(i * 4);
            tick();
        end
        retire_valid = 1'b0; halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        check("t2_instrs", instr_count, 3);
        check("t2_cycles", cycle_count, 4);
        check("t2_capturing", capturing, 0);
        check("t2_valid0", rd_valid, 1);
        check("t2_pc0", rd_pc, 0);
        check("t2_instr0", rd_instr, 32'h13);
        check("t2_last0", rd_last, 0);
        rd_ready = 1'b1;
        tick();
        check("t2_pc1", rd_pc, 4);
        check("t2_last1", rd_last, 0);
        tick();
        check("t2_pc2", rd_pc, 8);
        check("t2_instr2", rd_instr, 32'h1b);
        check("t2_last2", rd_last, 1);
        tick();
        check("t2_empty", rd_valid, 0);
        rd_ready = 1'b0;
        wait_done("t2_done");
        check("t2_done_rd_pc", rd_pc, 0);
        check("t2_done_instrs", instr_count, 3);

        // Re-arm from DONE, overflow with 20 retires
        do_arm();
        check("t6_capturing", capturing, 1);
        check("t6_cycles", cycle_count, 0);
        check("t6_instrs", instr_count, 0);
        check("t6_overflow", overflow, 0);
        for (int i = 0; i < 20; i++) begin
            retire_valid = 1'b1; retire_pc = 32'(i * 4); retire_instr = 32'h13 + 32'(i * 4);
            tick();
        end
        retire_valid = 1'b0; halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        check("t3_overflow", overflow, 1);
        check("t3_instrs", instr_count, 20);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t3_valid", rd_valid, 1);
            check("t3_pc", rd_pc, 64'(16 + 4 * i));
            check("t3_last", rd_last, (i == 15) ? 64'd1 : 64'd0);
            tick();
        end
        check("t3_empty", rd_valid, 0);
        rd_ready = 1'b0;
        wait_done("t3_done");
        check("t3_done_overflow", overflow, 1);

        // Retire in the halt cycle, consumer stalls
        do_arm();
        check("t4_overflow_cleared", overflow, 0);
        retire_valid = 1'b1; retire_pc = 32'd12; retire_instr = 32'h00c0_0093; halt_in = 1'b1;
        tick();
        retire_valid = 1'b0; halt_in = 1'b0;
        check("t4_instrs", instr_count, 1);
        check("t4_valid", rd_valid, 1);
        check("t4_pc", rd_pc, 12);
        check("t4_instr", rd_instr, 32'h00c0_0093);
        check("t4_last", rd_last, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_stall_valid", rd_valid, 1);
            check("t4_stall_pc", rd_pc, 12);
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("t4_popped", rd_valid, 0);
        wait_done("t4_done");

        // Watchdog: 64 capture cycles with no halt
        do_arm();
        for (int i = 0; i < 64; i++) tick();
        check("t5_cycles", cycle_count, 64);
`ifdef TRACE_WATCHDOG_EN
        check("t5_timeout", timeout, 1);
        check("t5_capturing", capturing, 0);
        check("t5_in_drain", done, 0);
        wait_done("t5_done");
        check("t5_cycles_hold", cycle_count, 64);
`else
        check("t5_timeout", timeout, 0);
        check("t5_capturing", capturing, 1);
        halt_in = 1'b1;
        tick();
        halt_in = 1'b0;
        check("t5_cycles_halt", cycle_count, 65);
        wait_done("t5_done");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
